// File: rtl/pipe_pkg.sv
// Shared payload types and constants for the elastic pipeline-stage registers
// that sit between the stages of the 5-stage RV32I core.
package pipe_pkg;

    localparam logic [31:0] RV_NOP         = 32'h0000_0013;
    localparam int          PERF_CNT_W_DEF = 16;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [15:0] ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    // A killed IF/ID slot must decode as addi x0,x0,0 rather than as all-zeros.
    localparam if_id_t IF_ID_BUBBLE = '{inst: RV_NOP, pc: 32'h0, pc_plus4: 32'h0};

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one pipeline-stage boundary: the upstream
// (in_*) and downstream (out_*) sides of a stage register.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = $bits(if_id_t)
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating event counter for stage performance monitoring; holds at all-ones
// and clears only on reset.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 1-entry skid buffer, stall and flush.
// Perf counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH = $bits(if_id_t),
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VAL = '0,
    parameter int                    CNT_WIDTH  = PERF_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_stage_skid_if.slave     bus,
    input  logic                 stall,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic [CNT_WIDTH-1:0] bubble_cnt
);

    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  push;
    logic                  pop;

    // in_ready depends only on local state, so out_ready never ripples upstream.
    assign bus.in_ready  = ~s_valid & ~stall & ~flush;
    assign bus.out_valid = m_valid & ~stall & ~flush;
    assign bus.out_data  = m_valid ? m_data : BUBBLE_VAL;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= BUBBLE_VAL;
            s_valid <= 1'b0;
            s_data  <= BUBBLE_VAL;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_data  <= BUBBLE_VAL;
            s_valid <= 1'b0;
            s_data  <= BUBBLE_VAL;
        end else if (!stall) begin
            if (!m_valid) begin
                if (push) begin
                    m_valid <= 1'b1;
                    m_data  <= bus.in_data;
                end
            end else if (pop) begin
                // A push alongside a pop implies the skid was empty.
                if (push) begin
                    m_data <= bus.in_data;
                end else if (s_valid) begin
                    m_data  <= s_data;
                    s_valid <= 1'b0;
                    s_data  <= BUBBLE_VAL;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (push) begin
                s_valid <= 1'b1;
                s_data  <= bus.in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush),
        .count (flush_cnt)
    );

    pipe_sat_counter #(.W(CNT_WIDTH)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.out_ready & ~bus.out_valid),
        .count (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios then random traffic,
// scored against a queue model of the beats held by the stage.
module tb_pipe_stage_skid;

    localparam int              DW     = 96;
    localparam int              CW     = 4;
    localparam logic [DW-1:0]   BUBBLE = '0;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit              PERF   = 1'b1;
`else
    localparam bit              PERF   = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic          flush;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] bubble_cnt;

    int checks;
    int errors;

    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_stall_cnt;
    logic [CW-1:0] exp_flush_cnt;
    logic [CW-1:0] exp_bubble_cnt;

    pipe_stage_skid_if #(.DATA_WIDTH(DW)) bus ();

    pipe_stage_skid #(
        .DATA_WIDTH (DW),
        .BUBBLE_VAL (BUBBLE),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .stall      (stall),
        .flush      (flush),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic ordy,
                                 input logic st, input logic fl);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        stall         = st;
        flush         = fl;
    endtask

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // Monitor: the stage is modelled as a FIFO of at most two beats; accepted
    // inputs are queued, and every beat the DUT hands off is popped and compared.
    always @(negedge clk) begin
        logic          m_out_valid;
        logic          m_in_ready;
        logic [DW-1:0] m_out_data;
        if (!rst_n) begin
            exp_q.delete();
            exp_stall_cnt  = '0;
            exp_flush_cnt  = '0;
            exp_bubble_cnt = '0;
            checkOutput("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
            checkOutput("rst_out_data", 128'(bus.out_data), 128'(BUBBLE));
            checkOutput("rst_stall_cnt", 128'(stall_cnt), 128'(0));
        end else begin
            m_out_valid = (exp_q.size() > 0) && !stall && !flush;
            m_in_ready  = (exp_q.size() < 2) && !stall && !flush;
            m_out_data  = (exp_q.size() > 0) ? exp_q[0] : BUBBLE;
            checkOutput("in_ready", 128'(bus.in_ready), 128'(m_in_ready));
            checkOutput("out_valid", 128'(bus.out_valid), 128'(m_out_valid));
            checkOutput("out_data", 128'(bus.out_data), 128'(m_out_data));
            checkOutput("stall_cnt", 128'(stall_cnt), 128'(PERF ? exp_stall_cnt : '0));
            checkOutput("flush_cnt", 128'(flush_cnt), 128'(PERF ? exp_flush_cnt : '0));
            checkOutput("bubble_cnt", 128'(bubble_cnt), 128'(PERF ? exp_bubble_cnt : '0));

            if (stall) exp_stall_cnt = satInc(exp_stall_cnt);
            if (flush) exp_flush_cnt = satInc(exp_flush_cnt);
            if (bus.out_ready && !m_out_valid) exp_bubble_cnt = satInc(exp_bubble_cnt);

            if (flush) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("spurious_beat", 128'(bus.out_data), 128'(BUBBLE));
                    end else begin
                        checkOutput("sb_beat", 128'(bus.out_data), 128'(exp_q.pop_front()));
                    end
                end else if (m_out_valid && bus.out_ready) begin
                    void'(exp_q.pop_front());
                end
                if (bus.in_valid && m_in_ready) exp_q.push_back(bus.in_data);
            end
        end
    end

    initial begin
        logic [DW-1:0] rnd;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back streaming with the consumer always ready.
        applyStimulus(1'b1, 96'hA1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 96'hA2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 96'hA3, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 96'h0,  1'b1, 1'b0, 1'b0);

        // Backpressure fills main and skid, then drains in order.
        applyStimulus(1'b1, 96'hB1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 96'hB2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 96'h0,  1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 96'h0, 1'b1, 1'b0, 1'b0);

        // Flush together with stall kills both held beats and the offered one.
        applyStimulus(1'b1, 96'hC1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 96'hC2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 96'hC3, 1'b0, 1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 96'h0, 1'b1, 1'b0, 1'b0);

        // Stall freezes a held beat, which is then presented exactly once.
        applyStimulus(1'b1, 96'hD1, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 96'h0, 1'b1, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 96'h0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with both entries full.
        applyStimulus(1'b1, 96'hE0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 96'hE9, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
        checkOutput("async_rst_out_data", 128'(bus.out_data), 128'(BUBBLE));
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 96'hE1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 96'h0,  1'b1, 1'b0, 1'b0);

        // Counter saturation from a clean reset.
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) applyStimulus(1'b0, 96'h0, 1'b0, 1'b1, 1'b0);
        repeat (2)  applyStimulus(1'b0, 96'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 96'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stall_cnt_saturated", 128'(stall_cnt), 128'(PERF ? 4'd15 : 4'd0));
        checkOutput("flush_cnt_two", 128'(flush_cnt), 128'(PERF ? 4'd2 : 4'd0));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 9) < 7), rnd, 1'($urandom_range(0, 9) < 7),
                          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0));
        end

        repeat (5) applyStimulus(1'b0, 96'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("drained", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
